add_pipe: RTL and testbench

Parametrised, pipelined, multi-mode adder with a valid/ready handshake on both sides. It succeeds the single-cycle registered 8-bit adder and adds configurable width and latency, unsigned/signed saturation, a running accumulator, and carry/saturation flags. It sits between a producer and a consumer that each follow valid/ready handshaking, so it can be dropped into datapaths that apply backpressure.

---
 rtl/add_pipe.sv | 111 +++++++++++
 tb/tb_add_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe.sv
// Pipelined multi-mode adder (wrap / unsigned sat / signed sat / accumulate) with
// valid/ready on both sides; stage 1 computes, later stages are pure delay.
module add_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    input  logic             in_acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_carry,
    output logic             out_sat
);

    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_USAT = 2'b01;
    localparam logic [1:0] MODE_SSAT = 2'b10;
    localparam logic [1:0] MODE_ACC  = 2'b11;

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] acc_sum;
    logic [WIDTH-1:0] y_d;
    logic             carry_d;
    logic             sat_d;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] s_q;
    logic [WIDTH-1:0]  y_q [STAGES];

    // A transfer happens on an edge where valid && ready; the whole pipe freezes
    // only while a result is waiting at the output and the consumer refuses it.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance && rst_n;
    assign accept   = in_valid && in_ready;

    always_comb begin
        acc_base = in_acc_clr ? '0 : acc;
        sum      = {1'b0, in_a} + {1'b0, in_b};
        acc_sum  = {2'b00, acc_base} + {2'b00, in_a} + {2'b00, in_b};
        y_d      = sum[WIDTH-1:0];
        carry_d  = sum[WIDTH];
        sat_d    = 1'b0;
        case (in_mode)
            MODE_WRAP: ;
            MODE_USAT: begin
                if (sum[WIDTH]) begin
                    y_d   = '1;
                    sat_d = 1'b1;
                end
            end
            MODE_SSAT: begin
                // Clamp toward the operands' common sign when the result sign flips.
                if ((in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1])) begin
                    y_d   = {in_a[WIDTH-1], {(WIDTH-1){~in_a[WIDTH-1]}}};
                    sat_d = 1'b1;
                end
            end
            MODE_ACC: begin
                y_d     = acc_sum[WIDTH-1:0];
                carry_d = |acc_sum[WIDTH+1:WIDTH];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            v_q <= '0;
            c_q <= '0;
            s_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                y_q[i] <= '0;
            end
        end else if (advance) begin
            v_q[0] <= accept;
            if (accept) begin
                y_q[0] <= y_d;
                c_q[0] <= carry_d;
                s_q[0] <= sat_d;
                if (in_mode == MODE_ACC) begin
                    acc <= acc_sum[WIDTH-1:0];
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                v_q[i] <= v_q[i-1];
                y_q[i] <= y_q[i-1];
                c_q[i] <= c_q[i-1];
                s_q[i] <= s_q[i-1];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_y     = y_q[STAGES-1];
    assign out_carry = c_q[STAGES-1];
    assign out_sat   = s_q[STAGES-1];

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: several WIDTH/STAGES instances, each with a driver, an
// integer-arithmetic reference model feeding an expected queue, and a monitor.
module tb_add_pipe;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int unsigned seed = 32'd20240611;
    logic clk = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int cfg, input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL cfg%0d %s got=%0h expected=%0h", cfg, name, act, want);
        end
    endtask

    for (genvar gi = 0; gi < 5; gi++) begin : g_cfg
        localparam int W = (gi == 2 || gi == 4) ? 16 : 8;
        localparam int S = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 2 : 4;
        localparam longint FULL = longint'(1) << W;

        logic         rst_n, in_valid, in_ready, in_acc_clr;
        logic         out_valid, out_ready, out_carry, out_sat;
        logic [W-1:0] in_a, in_b, out_y;
        logic [1:0]   in_mode;

        logic [W+1:0] exp_q [$];
        logic [W+1:0] held;
        longint m_acc   = 0;
        int first_edge  = 0;
        int rdy_pat     = 0;
        int rdy_cnt     = 0;
        bit have_first  = 0;
        bit seen_first  = 0;
        bit prev_stall  = 0;

        add_pipe #(.WIDTH(W), .STAGES(S)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_a       (in_a),
            .in_b       (in_b),
            .in_mode    (in_mode),
            .in_acc_clr (in_acc_clr),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_y      (out_y),
            .out_carry  (out_carry),
            .out_sat    (out_sat)
        );

        // Reference: plain integer arithmetic, result packed as {y, carry, sat}.
        function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] m, input logic clr, input longint acc_in);
            longint ua, ub, sum, sa, sb, ss, yv;
            logic c, s;
            ua  = longint'(a);
            ub  = longint'(b);
            sum = ua + ub;
            c   = (sum >= FULL);
            s   = 1'b0;
            yv  = sum % FULL;
            case (m)
                2'd1: if (c) begin yv = FULL - 1; s = 1'b1; end
                2'd2: begin
                    sa = (ua >= FULL / 2) ? ua - FULL : ua;
                    sb = (ub >= FULL / 2) ? ub - FULL : ub;
                    ss = sa + sb;
                    if (ss > FULL / 2 - 1) begin yv = FULL / 2 - 1; s = 1'b1; end
                    else if (ss < -(FULL / 2)) begin yv = FULL / 2; s = 1'b1; end
                end
                2'd3: begin
                    sum = (clr ? 64'sd0 : acc_in) + ua + ub;
                    c   = (sum >= FULL);
                    yv  = sum % FULL;
                end
                default: ;
            endcase
            return {yv[W-1:0], c, s};
        endfunction

        task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m, input logic clr);
            bit ok = 0;
            int n = 0;
            int edge_idx = 0;
            in_valid = 1'b1; in_a = a; in_b = b; in_mode = m; in_acc_clr = clr;
            while (!ok && n < 200) begin
                @(negedge clk);
                ok = in_ready;
                edge_idx = cyc + 1;
                @(posedge clk);
                n++;
            end
            check(gi, "accepted", ok, 1);
            if (ok) begin
                exp_q.push_back(model(a, b, m, clr, m_acc));
                if (m == 2'd3) m_acc = ((clr ? 64'sd0 : m_acc) + longint'(a) + longint'(b)) % FULL;
                if (!have_first) begin
                    have_first = 1;
                    first_edge = edge_idx;
                end
            end
            #1;
            in_valid = 1'b0;
        endtask

        task automatic send_rand();
            send(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        endtask

        task automatic idle(input int n);
            in_valid = 1'b0;
            repeat (n) @(posedge clk);
            #1;
        endtask

        task automatic do_reset();
            rst_n = 1'b0;
            in_valid = 1'b1;
            exp_q.delete();
            m_acc = 0;
            have_first = 0;
            seen_first = 0;
            first_edge = 0;
            @(negedge clk);
            check(gi, "rst_in_ready_pre", in_ready, 0);
            @(posedge clk);
            @(negedge clk);
            check(gi, "rst_out_valid", out_valid, 0);
            check(gi, "rst_out_y", out_y, 0);
            check(gi, "rst_out_carry", out_carry, 0);
            check(gi, "rst_out_sat", out_sat, 0);
            check(gi, "rst_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            in_valid = 1'b0;
        endtask

        initial begin
            out_ready = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                case (rdy_pat)
                    0: out_ready = 1'b1;
                    1: out_ready = (rdy_cnt % 3 == 0);
                    2: out_ready = 1'($urandom_range(0, 1));
                    default: out_ready = 1'b0;
                endcase
                rdy_cnt++;
            end
        end

        initial begin
            logic [W+1:0] want;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1) begin
                    if (prev_stall) begin
                        check(gi, "stall_valid", out_valid, 1);
                        check(gi, "stall_hold", {out_y, out_carry, out_sat}, held);
                    end
                    if (out_valid && !seen_first) begin
                        seen_first = 1;
                        check(gi, "first_latency", 64'(cyc - first_edge), 64'(S - 1));
                    end
                    if (out_valid && out_ready) begin
                        check(gi, "pending", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            want = exp_q.pop_front();
                            check(gi, "result", {out_y, out_carry, out_sat}, want);
                        end
                    end
                    prev_stall = out_valid && !out_ready;
                    held = {out_y, out_carry, out_sat};
                end else begin
                    prev_stall = 0;
                end
            end
        end

        initial begin
            logic [W-1:0] mx, smax, smin;
            mx   = '1;
            smax = {1'b0, {(W-1){1'b1}}};
            smin = {1'b1, {(W-1){1'b0}}};
            rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 2'd0; in_acc_clr = 1'b0;
            @(posedge clk);
            #1;
            do_reset();
            send(1, 2, 0, 0);
            send(mx, 1, 0, 0);
            send(200, 100, 1, 0);
            send(8'hAA, 8'h55, 1, 0);
            send(mx, mx, 1, 0);
            send(100, 100, 2, 0);
            send(8'h80, 8'hFF, 2, 0);
            send(8'h05, 8'hFE, 2, 0);
            send(smax, 1, 2, 0);
            send(smin, mx, 2, 0);
            send(smin, smin, 2, 0);
            send(10, 5, 3, 1);
            send(200, 50, 3, 0);
            send(1, 1, 3, 1);
            send(7, 9, 3, 0);
            do_reset();
            send(3, 0, 3, 0);
            idle(S + 2);
            // Fill the pipe against a stalled consumer, then reset while frozen.
            rdy_pat = 3;
            for (int i = 0; i < S; i++) send_rand();
            idle(3);
            rdy_pat = 0;
            do_reset();
            rdy_pat = 1;
            repeat (8) send_rand();
            rdy_pat = 2;
            repeat (32) begin
                send_rand();
                idle($urandom_range(0, 1));
            end
            rdy_pat = 0;
            for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
            repeat (S + 3) @(posedge clk);
            check(gi, "drained", exp_q.size(), 0);
            done_cnt++;
        end
    end

    initial begin
        $display("seed %0d", seed);
        void'($urandom(seed));
        for (int k = 0; k < 20000 && done_cnt < 5; k++) @(posedge clk);
        check(-1, "all_done", done_cnt, 5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
